// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles every non-clock, non-reset signal of the fetch unit:
//     - instruction-memory request  : imem_req_valid / imem_req_ready / imem_req_addr
//     - instruction-memory response : imem_resp_valid / imem_resp_data
//     - decode handshake            : Instruction / InstrPc / InstrValid / DecodeReady
//     - PC redirect                 : RedirectValid / RedirectTarget / MisalignErr
//     - statistics                  : InstrCount
//   master : the fetch unit side
//   slave  : the environment side (memory, decode, branch unit)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] Instruction;
    logic [31:0] InstrPc;
    logic        InstrValid;
    logic        DecodeReady;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        MisalignErr;
    logic [31:0] InstrCount;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output Instruction, InstrPc, InstrValid,
        input  DecodeReady,
        input  RedirectValid, RedirectTarget,
        output MisalignErr, InstrCount
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  Instruction, InstrPc, InstrValid,
        output DecodeReady,
        output RedirectValid, RedirectTarget,
        input  MisalignErr, InstrCount
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the single-cycle core. Holds the PC, keeps at most one
//   request outstanding to instruction memory, presents each returned word
//   and its PC to decode, and applies PC redirects while discarding any
//   response that belongs to the pre-redirect PC.
//
//   Ports:
//     clk  - core clock, rising edge
//     rst  - synchronous reset, active-high
//     bus  - instr_fetch_unit_if.master (memory request/response, decode
//            handshake, redirect, misalign pulse, accepted-instruction count)
//
//   Every output comes from a flip-flop; there is no combinational path
//   from any input to any output.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] redirect_pc;
    logic        req_valid_q;
    logic        req_valid_d;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic        misalign_q;
    logic [31:0] count_q;

    logic        resp_take;   // response captured for decode
    logic        decode_take; // decode consumed the held instruction
    logic        out_clear;   // held instruction leaves (consumed or squashed)

    // Bit 0 of the target is dropped by word alignment and does not feed
    // the misalign flag (only bit 1 does).
    logic        unused_target_bit;
    assign unused_target_bit = bus.RedirectTarget[0];

    assign redirect_pc = {bus.RedirectTarget[31:2], 2'b00};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic (redirect takes priority in every state)
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = bus.RedirectValid ? IDLE : REQ;
            end
            REQ: begin
                if (bus.RedirectValid) begin
                    // An accepted old-address request still owes a response.
                    state_nxt = bus.imem_req_ready ? DRAIN : REQ;
                end else if (bus.imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.RedirectValid) begin
                    state_nxt = bus.imem_resp_valid ? REQ : DRAIN;
                end else if (bus.imem_resp_valid) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (bus.RedirectValid || bus.DecodeReady) begin
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (bus.imem_resp_valid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // -----------------------------------------------------------------------
    always_comb begin
        req_valid_d = (state_nxt == REQ);
        resp_take   = (state == WAIT) && bus.imem_resp_valid && !bus.RedirectValid;
        decode_take = (state == OUT)  && bus.DecodeReady     && !bus.RedirectValid;
        out_clear   = (state == OUT)  && (bus.DecodeReady || bus.RedirectValid);
    end

    // -----------------------------------------------------------------------
    // Registered datapath and outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            req_valid_q   <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            count_q       <= 32'h0000_0000;
        end else begin
            req_valid_q <= req_valid_d;
            misalign_q  <= bus.RedirectValid && bus.RedirectTarget[1];

            if (bus.RedirectValid) begin
                pc <= redirect_pc;
            end else if (resp_take) begin
                pc <= pc + 32'd4;   // natural 32-bit wrap
            end

            if (resp_take) begin
                instr_q       <= bus.imem_resp_data;
                instr_pc_q    <= pc;
                instr_valid_q <= 1'b1;
            end else if (out_clear) begin
                instr_q       <= NOP_INSTR;
                instr_valid_q <= 1'b0;
            end

            if (decode_take) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // The request address is the PC register itself, so a redirect while a
    // request is being held shows up on the bus the following cycle.
    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.Instruction    = instr_q;
    assign bus.InstrPc        = instr_pc_q;
    assign bus.InstrValid     = instr_valid_q;
    assign bus.MisalignErr    = misalign_q;
    assign bus.InstrCount     = count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the immediate generator and decoder in the single-cycle core.
- Holds the PC and issues one outstanding request at a time to instruction memory over a valid/ready request and response interface.
- Presents each returned 32-bit instruction and its PC to decode with a valid/ready handshake.
- Accepts PC redirects (branch/JAL/JALR targets computed from PC + ImmData) and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on Instruction while no valid instruction is held.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid; only legal while a request is outstanding.
- imem_resp_data  in  32  fetched instruction word.
- Instruction  out  32  instruction to decode/ImmGenerator.
- InstrPc  out  32  PC of Instruction.
- InstrValid  out  1  Instruction/InstrPc valid.
- DecodeReady  in  1  decode consumes the instruction this cycle.
- RedirectValid  in  1  load a new PC; one-cycle pulse.
- RedirectTarget  in  32  new PC; bits [1:0] are forced to 0.
- MisalignErr  out  1  one-cycle pulse: RedirectTarget[1] was 1 on a redirect.
- InstrCount  out  32  count of instructions accepted by decode; wraps at 2^32.

Behaviour:
- Reset while rst=1, at any state, including mid-request:
  - pc=RESET_PC; state=IDLE.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - InstrValid=0, Instruction=NOP_INSTR, InstrPc=0.
  - MisalignErr=0, InstrCount=0.
  - A response arriving while rst=1 is ignored.
- All outputs are registered; no combinational input-to-output path.
- States are IDLE, REQ, WAIT, OUT and DRAIN.
- IDLE: go to REQ one cycle after rst deasserts.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready, go to WAIT. imem_req_valid drops the following cycle.
- WAIT, on imem_resp_valid:
  - Instruction<=imem_resp_data, InstrPc<=pc, InstrValid<=1.
  - pc<=pc+4, with 32-bit wrap (32'hFFFF_FFFC goes to 0).
  - Go to OUT.
- OUT:
  - Instruction, InstrPc and InstrValid are held stable while DecodeReady=0.
  - On DecodeReady: InstrValid<=0, Instruction<=NOP_INSTR, InstrCount++, go to REQ.
- DRAIN: wait for imem_resp_valid, discard the data, go to REQ.
- Latency: request accepted at cycle N → response at N+1 → InstrValid=1 at N+2 → next imem_req_valid at N+3 if DecodeReady=1.
- Redirect: when RedirectValid=1, pc<={RedirectTarget[31:2],2'b00}, and MisalignErr pulses next cycle if RedirectTarget[1]=1. Next state depends on the current state:
  - IDLE: the redirect is applied; stay IDLE.
  - REQ without imem_req_ready: stay in REQ; imem_req_addr takes the new pc next cycle. This is the only case where the address changes while valid is held.
  - REQ with imem_req_ready: the old-address request is issued; go to DRAIN.
  - WAIT without imem_resp_valid: go to DRAIN.
  - WAIT with imem_resp_valid: the response is discarded; go to REQ.
  - OUT: InstrValid<=0 and Instruction<=NOP_INSTR. Not counted even if DecodeReady=1. Go to REQ.
  - DRAIN: pc is updated; stay in DRAIN. If imem_resp_valid arrives the same cycle, it is discarded and the next state is REQ.
- Redirect has priority over all normal transitions.
- Never more than one outstanding request. imem_resp_valid outside WAIT/DRAIN is ignored.

Test Plan:
- Reset/sequential fetch: rst=1 for 2 cycles, memory returns data=address, DecodeReady=1 → requests at 0x0, 0x4, 0x8. InstrPc/Instruction = 0x0/0x0, 0x4/0x4, 0x8/0x8. Request-to-InstrValid is 2 cycles; InstrCount=3.
- Decode stall: InstrValid=1 with 0x00500093 at PC 0x4, DecodeReady=0 for 5 cycles → Instruction/InstrPc stable, no new imem_req_valid, InstrCount unchanged. DecodeReady=1 then gives the next request at 0x8.
- Redirect in WAIT: request for 0x10 accepted, RedirectValid with target 0x200 next cycle, response 0xDEADBEEF one cycle later → response never appears on Instruction. Next request addr 0x200; InstrCount unchanged.
- Redirect coincident with response in WAIT and with handshake in REQ: for each case, the stale word is dropped and exactly one request is issued to the target. Response in WAIT goes straight to REQ; handshake in REQ goes through DRAIN.
- Misaligned/wrap: target 0x0000_0106 → MisalignErr=1 for one cycle, fetch addr 0x104. Redirect to 0xFFFFFFFC and accept → next fetch addr 0x0.
- Reset mid-WAIT: rst asserted while a response is pending → all outputs at reset values. A response arriving during rst is ignored; after release the first fetch is at RESET_PC.
